branch_ckpt_stack_mw: RTL and testbench

//  Multi-way branch checkpoint stack: next generation of the R10K branch stack. Up to DISP_W branches allocate
//  per cycle, each with an opaque restore payload (PC_restore, ROB tail, free list, map table, packed by dispatch).

---
 rtl/branch_ckpt_stack_mw.sv | 149 ++++++++++++++
 tb/tb_branch_ckpt_stack_mw.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ckpt_stack_mw.sv
// Multi-way branch checkpoint stack: allocates up to DISP_W one-hot tagged checkpoints per cycle
// and resolves one branch per cycle, clearing dependency bits or squashing with a registered restore.
module branch_ckpt_stack_mw #(
    parameter int NUM_CKPT  = 4,
    parameter int DISP_W    = 2,
    parameter int PAYLOAD_W = 128
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [DISP_W-1:0]             alloc_req,
    input  logic [DISP_W*PAYLOAD_W-1:0]   alloc_payload,
    output logic [DISP_W-1:0]             alloc_gnt,
    output logic [DISP_W*NUM_CKPT-1:0]    alloc_tag,
    output logic [DISP_W*NUM_CKPT-1:0]    alloc_dep_mask,
    output logic [NUM_CKPT-1:0]           cur_mask,
    output logic [$clog2(NUM_CKPT+1)-1:0] free_cnt,
    input  logic                          res_valid,
    input  logic [NUM_CKPT-1:0]           res_tag,
    input  logic                          res_mispred,
    output logic [NUM_CKPT-1:0]           bmm_out,
    output logic                          bmm_squash,
    output logic                          restore_valid,
    output logic [PAYLOAD_W-1:0]          restore_payload,
    output logic [NUM_CKPT-1:0]           restore_mask,
    output logic                          err_sticky
);
    localparam int CW = $clog2(NUM_CKPT+1);

    logic [NUM_CKPT-1:0]  valid_q;
    logic [NUM_CKPT-1:0]  mask_q    [NUM_CKPT];
    logic [PAYLOAD_W-1:0] payload_q [NUM_CKPT];

    logic                 res_legal, res_ok, res_squash, res_illegal;
    logic [PAYLOAD_W-1:0] sel_payload;
    logic [NUM_CKPT-1:0]  sel_mask;
    logic [NUM_CKPT-1:0]  grant_tags, acc, lane_tag, valid_nxt;
    logic [NUM_CKPT-1:0]  ent_mask    [NUM_CKPT];
    logic [PAYLOAD_W-1:0] ent_payload [NUM_CKPT];
    logic [CW-1:0]        used_cnt;

    // A resolve is only acted on when it names exactly one live entry.
    always_comb begin
        res_legal   = res_valid && (res_tag != '0) &&
                      ((res_tag & (res_tag - NUM_CKPT'(1))) == '0) &&
                      ((res_tag & valid_q) != '0);
        res_ok      = res_legal && !res_mispred;
        res_squash  = res_legal && res_mispred;
        res_illegal = res_valid && !res_legal;
        sel_payload = '0;
        sel_mask    = '0;
        for (int e = 0; e < NUM_CKPT; e++) begin
            if (res_tag[e]) begin
                sel_payload = sel_payload | payload_q[e];
                sel_mask    = sel_mask | mask_q[e];
            end
        end
    end

    // Lane i takes the i-th free entry; freed-this-cycle entries are not visible here.
    always_comb begin
        alloc_gnt      = '0;
        alloc_tag      = '0;
        alloc_dep_mask = '0;
        grant_tags     = '0;
        acc            = cur_mask;
        lane_tag       = '0;
        for (int e = 0; e < NUM_CKPT; e++) begin
            ent_mask[e]    = '0;
            ent_payload[e] = '0;
        end
        for (int i = 0; i < DISP_W; i++) begin
            lane_tag = '0;
            for (int e = 0; e < NUM_CKPT; e++) begin
                if (!valid_q[e] && !grant_tags[e] && (lane_tag == '0))
                    lane_tag[e] = 1'b1;
            end
            alloc_dep_mask[i*NUM_CKPT +: NUM_CKPT] = acc;
            if (alloc_req[i] && (i < int'(free_cnt)) && !(res_valid && res_mispred)) begin
                alloc_gnt[i]                      = 1'b1;
                alloc_tag[i*NUM_CKPT +: NUM_CKPT] = lane_tag;
                for (int e = 0; e < NUM_CKPT; e++) begin
                    if (lane_tag[e]) begin
                        ent_mask[e]    = acc & ~(res_ok ? res_tag : '0);
                        ent_payload[e] = alloc_payload[i*PAYLOAD_W +: PAYLOAD_W];
                    end
                end
                grant_tags = grant_tags | lane_tag;
                acc        = acc | lane_tag;
            end
        end
    end

    always_comb begin
        valid_nxt = valid_q;
        for (int e = 0; e < NUM_CKPT; e++) begin
            if ((res_ok && res_tag[e]) ||
                (res_squash && (res_tag[e] || ((mask_q[e] & res_tag) != '0))))
                valid_nxt[e] = 1'b0;
        end
        valid_nxt = valid_nxt | grant_tags;
        used_cnt  = '0;
        for (int e = 0; e < NUM_CKPT; e++)
            used_cnt = used_cnt + CW'(valid_nxt[e]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            cur_mask <= '0;
            free_cnt <= CW'(NUM_CKPT);
            for (int e = 0; e < NUM_CKPT; e++) begin
                mask_q[e]    <= '0;
                payload_q[e] <= '0;
            end
        end else begin
            valid_q  <= valid_nxt;
            cur_mask <= valid_nxt;
            free_cnt <= CW'(NUM_CKPT) - used_cnt;
            for (int e = 0; e < NUM_CKPT; e++) begin
                if (grant_tags[e]) begin
                    mask_q[e]    <= ent_mask[e];
                    payload_q[e] <= ent_payload[e];
                end else if (res_ok) begin
                    mask_q[e] <= mask_q[e] & ~res_tag;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bmm_out         <= '0;
            bmm_squash      <= 1'b0;
            restore_valid   <= 1'b0;
            restore_payload <= '0;
            restore_mask    <= '0;
            err_sticky      <= 1'b0;
        end else begin
            bmm_out       <= res_legal ? res_tag : '0;
            bmm_squash    <= res_squash;
            restore_valid <= res_squash;
            if (res_squash) begin
                restore_payload <= sel_payload;
                restore_mask    <= sel_mask;
            end
            err_sticky <= err_sticky | res_illegal;
        end
    end
endmodule

// File: tb/tb_branch_ckpt_stack_mw.sv
// Self-checking bench for branch_ckpt_stack_mw: directed scenarios plus randomized traffic
// checked against a set-based checkpoint model.
module tb_branch_ckpt_stack_mw;
    logic         clock, reset_n;
    logic [1:0]   alloc_req;
    logic [255:0] alloc_payload;
    logic [1:0]   alloc_gnt;
    logic [7:0]   alloc_tag, alloc_dep_mask;
    logic [3:0]   cur_mask;
    logic [2:0]   free_cnt;
    logic         res_valid, res_mispred;
    logic [3:0]   res_tag;
    logic [3:0]   bmm_out;
    logic         bmm_squash, restore_valid;
    logic [127:0] restore_payload;
    logic [3:0]   restore_mask;
    logic         err_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    branch_ckpt_stack_mw #(.NUM_CKPT(4), .DISP_W(2), .PAYLOAD_W(128)) dut (
        .clock(clock), .reset_n(reset_n),
        .alloc_req(alloc_req), .alloc_payload(alloc_payload),
        .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag), .alloc_dep_mask(alloc_dep_mask),
        .cur_mask(cur_mask), .free_cnt(free_cnt),
        .res_valid(res_valid), .res_tag(res_tag), .res_mispred(res_mispred),
        .bmm_out(bmm_out), .bmm_squash(bmm_squash),
        .restore_valid(restore_valid), .restore_payload(restore_payload),
        .restore_mask(restore_mask), .err_sticky(err_sticky)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: each checkpoint is live or not, with the set of branches it depends on.
    bit           m_live [4];
    logic [3:0]   m_dep  [4];
    logic [127:0] m_pl   [4];
    bit           m_err;
    logic [3:0]   e_bmm, e_rmask;
    bit           e_sq, e_rv;
    logic [127:0] e_rpl;
    logic [1:0]   exp_gnt;
    logic [3:0]   exp_tag [2];
    logic [3:0]   exp_dep [2];

    function automatic logic [3:0] live_set();
        logic [3:0] v = '0;
        for (int e = 0; e < 4; e++) if (m_live[e]) v[e] = 1'b1;
        return v;
    endfunction

    function automatic int live_count();
        int n = 0;
        for (int e = 0; e < 4; e++) if (m_live[e]) n++;
        return n;
    endfunction

    function automatic void model_reset();
        for (int e = 0; e < 4; e++) begin
            m_live[e] = 0; m_dep[e] = '0; m_pl[e] = '0;
        end
        m_err = 0; e_bmm = '0; e_sq = 0; e_rv = 0; e_rpl = '0; e_rmask = '0;
    endfunction

    function automatic void model_comb();
        int         free_list[$];
        logic [3:0] older;
        for (int e = 0; e < 4; e++) if (!m_live[e]) free_list.push_back(e);
        older = live_set();
        for (int i = 0; i < 2; i++) begin
            exp_dep[i] = older;
            exp_tag[i] = '0;
            exp_gnt[i] = 1'b0;
            if (alloc_req[i] && i < free_list.size() && !(res_valid && res_mispred)) begin
                exp_gnt[i] = 1'b1;
                exp_tag[i] = 4'(1 << free_list[i]);
                older      = older | exp_tag[i];
            end
        end
    endfunction

    function automatic void model_commit();
        int idx = -1;
        if ($countones(res_tag) == 1)
            for (int e = 0; e < 4; e++) if (res_tag[e] && m_live[e]) idx = e;
        e_bmm = '0; e_sq = 0; e_rv = 0;
        if (res_valid && idx < 0) begin
            m_err = 1;
        end else if (res_valid && !res_mispred) begin
            e_bmm = res_tag;
            m_live[idx] = 0;
            for (int e = 0; e < 4; e++) m_dep[e] = m_dep[e] & ~res_tag;
        end else if (res_valid) begin
            e_bmm = res_tag; e_sq = 1; e_rv = 1;
            e_rpl = m_pl[idx]; e_rmask = m_dep[idx];
            for (int e = 0; e < 4; e++)
                if (e == idx || (m_dep[e] & res_tag) != '0) m_live[e] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            for (int e = 0; e < 4; e++) begin
                if (exp_gnt[i] && exp_tag[i][e]) begin
                    m_live[e] = 1;
                    m_dep[e]  = exp_dep[i] & ~((res_valid && !res_mispred && idx >= 0) ? res_tag : 4'b0);
                    m_pl[e]   = alloc_payload[i*128 +: 128];
                end
            end
        end
    endfunction

    task automatic apply(input logic [1:0] req, input logic rv, input logic [3:0] rtag, input logic rmis);
        alloc_req     = req;
        alloc_payload = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        res_valid     = rv;
        res_tag       = rtag;
        res_mispred   = rmis;
        model_comb();
        #1;
    endtask

    task automatic clk_step();
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        alloc_req = '0; alloc_payload = '0; res_valid = 0; res_tag = '0; res_mispred = 0;
        model_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (cur_mask !== 4'b0) begin n_fail++; $display("FAIL reset_cur_mask got %b exp 0000", cur_mask); end
        n_tests++; if (free_cnt !== 3'd4) begin n_fail++; $display("FAIL reset_free_cnt got %0d exp 4", free_cnt); end
        n_tests++; if ({bmm_out, bmm_squash, restore_valid, restore_mask, err_sticky} !== 11'b0) begin
            n_fail++; $display("FAIL reset_outputs got %b%b%b%b%b exp 0", bmm_out, bmm_squash, restore_valid, restore_mask, err_sticky); end
        n_tests++; if (restore_payload !== 128'b0) begin n_fail++; $display("FAIL reset_payload got %h exp 0", restore_payload); end
    endtask

    task automatic test_basic_alloc();
        do_reset();
        apply(2'b11, 0, 4'b0, 0);
        n_tests++; if (alloc_gnt !== 2'b11) begin n_fail++; $display("FAIL basic_gnt got %b exp 11", alloc_gnt); end
        n_tests++; if (alloc_tag !== 8'b0010_0001) begin n_fail++; $display("FAIL basic_tag got %b exp 00100001", alloc_tag); end
        n_tests++; if (alloc_dep_mask !== 8'b0001_0000) begin n_fail++; $display("FAIL basic_dep got %b exp 00010000", alloc_dep_mask); end
        clk_step();
        n_tests++; if (cur_mask !== 4'b0011) begin n_fail++; $display("FAIL basic_cur_mask got %b exp 0011", cur_mask); end
        n_tests++; if (free_cnt !== 3'd2) begin n_fail++; $display("FAIL basic_free_cnt got %0d exp 2", free_cnt); end
    endtask

    task automatic test_full_and_correct();
        apply(2'b11, 0, 4'b0, 0);
        clk_step();
        apply(2'b11, 0, 4'b0, 0);
        n_tests++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL full_gnt got %b exp 00", alloc_gnt); end
        n_tests++; if (free_cnt !== 3'd0) begin n_fail++; $display("FAIL full_free_cnt got %0d exp 0", free_cnt); end
        clk_step();
        apply(2'b00, 1, 4'b0010, 0);
        clk_step();
        n_tests++; if (bmm_out !== 4'b0010 || bmm_squash !== 1'b0) begin
            n_fail++; $display("FAIL correct_bmm got %b/%b exp 0010/0", bmm_out, bmm_squash); end
        n_tests++; if (cur_mask !== 4'b1101) begin n_fail++; $display("FAIL correct_cur_mask got %b exp 1101", cur_mask); end
        n_tests++; if (free_cnt !== 3'd1) begin n_fail++; $display("FAIL correct_free_cnt got %0d exp 1", free_cnt); end
    endtask

    task automatic test_mispredict_chain();
        logic [127:0] pl1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            apply(2'b01, 0, 4'b0, 0);
            if (k == 1) pl1 = alloc_payload[127:0];
            clk_step();
        end
        apply(2'b00, 1, 4'b0010, 1);
        clk_step();
        n_tests++; if (restore_valid !== 1'b1 || bmm_squash !== 1'b1 || bmm_out !== 4'b0010) begin
            n_fail++; $display("FAIL mis_strobes got rv=%b sq=%b bmm=%b exp 1 1 0010", restore_valid, bmm_squash, bmm_out); end
        n_tests++; if (restore_mask !== 4'b0001) begin n_fail++; $display("FAIL mis_restore_mask got %b exp 0001", restore_mask); end
        n_tests++; if (restore_payload !== pl1) begin n_fail++; $display("FAIL mis_payload got %h exp %h", restore_payload, pl1); end
        n_tests++; if (cur_mask !== 4'b0001 || free_cnt !== 3'd3) begin
            n_fail++; $display("FAIL mis_state got %b/%0d exp 0001/3", cur_mask, free_cnt); end
        apply(2'b00, 0, 4'b0, 0);
        clk_step();
        n_tests++; if (restore_valid !== 1'b0 || bmm_out !== 4'b0 || bmm_squash !== 1'b0) begin
            n_fail++; $display("FAIL mis_one_cycle got rv=%b bmm=%b sq=%b exp 0 0000 0", restore_valid, bmm_out, bmm_squash); end
    endtask

    task automatic test_mispred_blocks_alloc();
        apply(2'b11, 1, 4'b0001, 1);
        n_tests++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL misalloc_gnt got %b exp 00", alloc_gnt); end
        clk_step();
        n_tests++; if (cur_mask !== 4'b0000 || free_cnt !== 3'd4) begin
            n_fail++; $display("FAIL misalloc_state got %b/%0d exp 0000/4", cur_mask, free_cnt); end
    endtask

    task automatic test_same_cycle_clear();
        do_reset();
        apply(2'b01, 0, 4'b0, 0);
        clk_step();
        apply(2'b01, 1, 4'b0001, 0);
        n_tests++; if (alloc_gnt !== 2'b01 || alloc_tag[3:0] !== 4'b0010) begin
            n_fail++; $display("FAIL sameclr_gnt got %b/%b exp 01/0010", alloc_gnt, alloc_tag[3:0]); end
        clk_step();
        n_tests++; if (cur_mask !== 4'b0010) begin n_fail++; $display("FAIL sameclr_cur_mask got %b exp 0010", cur_mask); end
        apply(2'b00, 1, 4'b0010, 1);
        clk_step();
        n_tests++; if (restore_valid !== 1'b1 || restore_mask !== 4'b0000) begin
            n_fail++; $display("FAIL sameclr_stored_mask got rv=%b mask=%b exp 1 0000", restore_valid, restore_mask); end
    endtask

    task automatic test_illegal();
        do_reset();
        apply(2'b11, 0, 4'b0, 0);
        clk_step();
        apply(2'b00, 1, 4'b0110, 0);
        clk_step();
        n_tests++; if (err_sticky !== 1'b1 || bmm_out !== 4'b0) begin
            n_fail++; $display("FAIL illegal_multi got err=%b bmm=%b exp 1 0000", err_sticky, bmm_out); end
        n_tests++; if (cur_mask !== 4'b0011 || free_cnt !== 3'd2) begin
            n_fail++; $display("FAIL illegal_state got %b/%0d exp 0011/2", cur_mask, free_cnt); end
        apply(2'b00, 1, 4'b1000, 1);
        clk_step();
        n_tests++; if (restore_valid !== 1'b0 || cur_mask !== 4'b0011 || err_sticky !== 1'b1) begin
            n_fail++; $display("FAIL illegal_invalid got rv=%b cm=%b err=%b exp 0 0011 1", restore_valid, cur_mask, err_sticky); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(2'b01, 0, 4'b0, 0);
        clk_step();
        apply(2'b01, 0, 4'b0, 0);
        clk_step();
        apply(2'b00, 1, 4'b0001, 1);
        clk_step();
        n_tests++; if (restore_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b exp 1", restore_valid); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (restore_valid !== 1'b0 || restore_payload !== 128'b0 || restore_mask !== 4'b0 || bmm_squash !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_restore got rv=%b mask=%b sq=%b exp 0 0000 0", restore_valid, restore_mask, bmm_squash); end
        n_tests++; if (cur_mask !== 4'b0 || free_cnt !== 3'd4 || bmm_out !== 4'b0) begin
            n_fail++; $display("FAIL rstmid_state got %b/%0d/%b exp 0000/4/0000", cur_mask, free_cnt, bmm_out); end
        do_reset();
    endtask

    task automatic test_random();
        logic [1:0] req;
        logic [3:0] tag;
        int         live_q[$];
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 2))
                0: req = 2'b00;
                1: req = 2'b01;
                default: req = 2'b11;
            endcase
            live_q.delete();
            for (int e = 0; e < 4; e++) if (m_live[e]) live_q.push_back(e);
            if (live_q.size() > 0 && $urandom_range(0, 5) != 0)
                tag = 4'(1 << live_q[$urandom_range(0, live_q.size()-1)]);
            else
                tag = 4'($urandom);
            apply(req, ($urandom_range(0, 1) == 1), tag, ($urandom_range(0, 9) < 3));
            n_tests++; if (alloc_gnt !== exp_gnt || alloc_tag !== {exp_tag[1], exp_tag[0]} || alloc_dep_mask !== {exp_dep[1], exp_dep[0]}) begin
                n_fail++; $display("FAIL rnd_alloc cyc %0d got %b/%b/%b exp %b/%b%b/%b%b", n, alloc_gnt, alloc_tag, alloc_dep_mask,
                                   exp_gnt, exp_tag[1], exp_tag[0], exp_dep[1], exp_dep[0]); end
            clk_step();
            n_tests++; if (cur_mask !== live_set() || free_cnt !== 3'(4 - live_count())) begin
                n_fail++; $display("FAIL rnd_state cyc %0d got %b/%0d exp %b/%0d", n, cur_mask, free_cnt, live_set(), 4 - live_count()); end
            n_tests++; if (bmm_out !== e_bmm || bmm_squash !== e_sq || restore_valid !== e_rv || err_sticky !== m_err) begin
                n_fail++; $display("FAIL rnd_bcast cyc %0d got %b/%b/%b/%b exp %b/%b/%b/%b", n, bmm_out, bmm_squash, restore_valid, err_sticky,
                                   e_bmm, e_sq, e_rv, m_err); end
            n_tests++; if (restore_payload !== e_rpl || restore_mask !== e_rmask) begin
                n_fail++; $display("FAIL rnd_restore cyc %0d got %h/%b exp %h/%b", n, restore_payload, restore_mask, e_rpl, e_rmask); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        alloc_req = '0; alloc_payload = '0; res_valid = 0; res_tag = '0; res_mispred = 0;
        test_reset();
        test_basic_alloc();
        test_full_and_correct();
        test_mispredict_chain();
        test_mispred_blocks_alloc();
        test_same_cycle_clear();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
